// File: rtl/register_file.sv
// ----------------------------------------------------------------------------
// register_file
// Architectural integer register file for the single-cycle RV32 core.
// 32 x 32-bit registers, two combinational read ports (rs1/rs2) and one
// synchronous write port (rd). x0 has no storage and always reads zero.
// The whole array clears asynchronously when RST_N is low.
// ----------------------------------------------------------------------------
module register_file (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        WE3,
   input  logic [4:0]  A1,
   input  logic [4:0]  A2,
   input  logic [4:0]  A3,
   input  logic [31:0] WD3,
   output logic [31:0] RD1,
   output logic [31:0] RD2
);

   // Storage for x1..x31 only; x0 is a constant zero and never stored.
   logic [31:1][31:0] r_regs;

   // One-hot write select, one bit per writable register.
   logic [31:1]       w_wr_sel;

   // Reads of x0 return zero, every other address returns stored contents.
   function automatic logic [31:0] read_reg(input logic [4:0]        addr,
                                            input logic [31:1][31:0] regs);
      logic [31:0] v;
      if (addr == 5'd0) begin
         v = 32'h0000_0000;
      end else begin
         v = regs[addr];
      end
      return v;
   endfunction

   // Decode the write address into a one-hot select; A3 = 0 matches nothing.
   always_comb begin
      w_wr_sel = '0;
      for (int i = 1; i < 32; i++) begin
         w_wr_sel[i] = WE3 & (A3 == 5'(i));
      end
   end

   // Register array: async clear on reset, otherwise write the selected entry.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_regs <= '0;
      end else begin
         for (int i = 1; i < 32; i++) begin
            if (w_wr_sel[i]) begin
               r_regs[i] <= WD3;
            end
         end
      end
   end

   // Combinational read ports with no write bypass: old data until the edge.
   always_comb begin
      RD1 = read_reg(A1, r_regs);
      RD2 = read_reg(A2, r_regs);
   end

endmodule

// File: tb/tb_register_file.sv
// ----------------------------------------------------------------------------
// tb_register_file
// Self-checking bench for register_file: directed scenarios plus randomized
// traffic compared against a plain array model of the architectural state.
// ----------------------------------------------------------------------------
module tb_register_file;

   logic        CLK;
   logic        RST_N;
   logic        WE3;
   logic [4:0]  A1;
   logic [4:0]  A2;
   logic [4:0]  A3;
   logic [31:0] WD3;
   logic [31:0] RD1;
   logic [31:0] RD2;

   int unsigned n_tests;
   int unsigned n_fail;

   // Reference model: architectural register values, x0 kept at zero.
   logic [31:0] model [32];

   register_file dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .WE3   (WE3),
      .A1    (A1),
      .A2    (A2),
      .A3    (A3),
      .WD3   (WD3),
      .RD1   (RD1),
      .RD2   (RD2)
   );

   // Free-running 10 ns clock.
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h, expected %08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_read(input logic [4:0] a);
      return (a == 5'd0) ? 32'h0 : model[a];
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
   endtask

   // Advance one rising edge, apply write semantics to the model, settle.
   task automatic step();
      @(posedge CLK);
      if (RST_N && WE3 && (A3 != 5'd0)) model[A3] = WD3;
      #1;
   endtask

   task automatic wr(input logic [4:0] a, input logic [31:0] d);
      WE3 = 1'b1; A3 = a; WD3 = d;
      step();
      WE3 = 1'b0;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      model_clear();
      RST_N = 1'b0; WE3 = 1'b0; A3 = 5'd0; WD3 = 32'h0;
      A1 = 5'($urandom_range(31, 1)); A2 = 5'($urandom_range(31, 1));
      #12;
      check("reset_rd1", RD1, 32'h0);
      check("reset_rd2", RD2, 32'h0);

      // Write attempted while reset is held must be ignored.
      WE3 = 1'b1; A3 = A1; WD3 = 32'hCAFE_F00D;
      step();
      WE3 = 1'b0;
      check("reset_wr_ignored", RD1, 32'h0);

      @(negedge CLK);
      RST_N = 1'b1;
      for (int i = 0; i < 10; i++) begin
         A1 = 5'($urandom); A2 = 5'($urandom);
         step();
         check("idle_rd1", RD1, 32'h0);
         check("idle_rd2", RD2, 32'h0);
      end

      // Basic write/read.
      wr(5'd5, 32'd42);
      wr(5'd10, 32'd100);
      A1 = 5'd5; A2 = 5'd10; #1;
      check("basic_x5", RD1, 32'd42);
      check("basic_x10", RD2, 32'd100);

      // Overwrite.
      wr(5'd5, 32'd77);
      #1;
      check("ovw_x5", RD1, 32'd77);
      check("ovw_x10", RD2, 32'd100);

      // x0 protection.
      wr(5'd0, 32'hDEAD_BEEF);
      A1 = 5'd0; A2 = 5'd0; #1;
      check("x0_rd1", RD1, 32'h0);
      check("x0_rd2", RD2, 32'h0);

      // Write enable low.
      WE3 = 1'b0; A3 = 5'd5; WD3 = 32'd123;
      for (int i = 0; i < 4; i++) step();
      A1 = 5'd5; A2 = 5'd5; #1;
      check("we_low_rd1", RD1, 32'd77);
      check("we_low_rd2", RD2, 32'd77);

      // Read-during-write: old value before edge, new value after.
      A1 = 5'd10; WE3 = 1'b1; A3 = 5'd10; WD3 = 32'd55; #1;
      check("rdw_before", RD1, 32'd100);
      step();
      WE3 = 1'b0;
      check("rdw_after", RD1, 32'd55);

      // Back-to-back writes to one register: each visible for one cycle.
      A1 = 5'd7;
      WE3 = 1'b1; A3 = 5'd7; WD3 = 32'h1111_1111;
      step();
      check("b2b_first", RD1, 32'h1111_1111);
      WD3 = 32'h2222_2222;
      step();
      WE3 = 1'b0;
      check("b2b_second", RD1, 32'h2222_2222);

      // Async reset mid-cycle with a coincident write pending.
      @(negedge CLK);
      A1 = 5'd10; A2 = 5'd7;
      WE3 = 1'b1; A3 = 5'd10; WD3 = 32'h5A5A_5A5A;
      #2;
      RST_N = 1'b0;
      model_clear();
      #1;
      check("async_rst_rd1", RD1, 32'h0);
      check("async_rst_rd2", RD2, 32'h0);
      step();
      check("rst_overrides_wr", RD1, 32'h0);
      @(negedge CLK);
      RST_N = 1'b1;
      WD3 = 32'h0BAD_F00D;
      step();
      WE3 = 1'b0;
      check("first_wr_after_rst", RD1, 32'h0BAD_F00D);

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         WE3 = ($urandom_range(3, 0) != 0);
         A3  = 5'($urandom);
         WD3 = $urandom;
         A1  = 5'($urandom);
         A2  = ($urandom_range(7, 0) == 0) ? A1 : 5'($urandom);
         if ($urandom_range(9, 0) == 0) A3 = 5'd0;
         #1;
         check("rnd_pre_rd1", RD1, model_read(A1));
         check("rnd_pre_rd2", RD2, model_read(A2));
         step();
         check("rnd_post_rd1", RD1, model_read(A1));
         check("rnd_post_rd2", RD2, model_read(A2));
      end

      // Sweep every address through both ports.
      WE3 = 1'b0;
      for (int a = 0; a < 32; a++) begin
         A1 = 5'(a); A2 = 5'(31 - a); #1;
         check("sweep_rd1", RD1, model_read(A1));
         check("sweep_rd2", RD2, model_read(A2));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
